scsi_io_arbiter: RTL and testbench
==================================

SCSI_IO_ARBITER -- requirements
Module: scsi_io_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 24'd1000000, giving the number of cycles to wait for sd_ack (used only with SCSI_ARB_TIMEOUT_EN).
REQ-002 SHALL provide port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL provide port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL provide ports io_lba0 and io_lba1, input, 32 each, block address from SCSI target 0 and 1.
REQ-005 SHALL provide ports io_rd0, io_wr0, io_rd1 and io_wr1, input, 1 each, level requests held until the matching io_ack.
REQ-006 SHALL provide ports io_ack0 and io_ack1, output, 1 each, per-target acknowledge.
REQ-007 SHALL provide ports sd_buff_din0 and sd_buff_din1, input, 8 each, buffer read data from each target.
REQ-008 SHALL provide ports sd_buff_wr0 and sd_buff_wr1, output, 1 each, per-target buffer write strobes.
REQ-009 SHALL provide ports sd_buff_addr_o and sd_buff_dout_o, output, 9 and 8, fanned to both targets unmodified.
REQ-010 SHALL provide port sd_lba, output, 32; ports sd_rd and sd_wr, output, 1 each; port sd_ack, input, 1; all toward the IO controller.
REQ-011 SHALL provide ports sd_buff_addr, input, 9; sd_buff_dout, input, 8; sd_buff_din, output, 8; sd_buff_wr, input, 1; all on the IO controller side.
REQ-012 SHALL provide port grant, output, 1, the currently owning target (0/1).
REQ-013 SHALL provide port busy, output, 1, high when the FSM state is not IDLE.
REQ-014 SHALL provide port err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, REQ and ACK.
REQ-016 In IDLE with any io_rdN|io_wrN high, the block SHALL select a port round-robin, preferring the port not served last, and latch grant, sd_lba=io_lbaN and direction, then enter REQ.
REQ-017 For same-port io_rdN and io_wrN both high, the block SHALL take read.
REQ-018 sd_rd/sd_wr SHALL be registered and high exactly while the state is REQ, beginning the cycle after the grant decision.
REQ-019 REQ SHALL move to ACK on the first cycle sd_ack=1; sd_rd/sd_wr SHALL be low from the next cycle.
REQ-020 ACK SHALL move to IDLE on the first cycle sd_ack=0 and record the served port as last.
REQ-021 io_ackN SHALL be combinational: sd_ack & busy & (grant==N); the non-granted port ack SHALL be 0.
REQ-022 sd_buff_wrN SHALL equal sd_buff_wr & busy & (grant==N); sd_buff_din SHALL be sd_buff_din[grant], or 0 when idle.
REQ-023 Requests arriving while busy SHALL wait; the block SHALL not drop or queue them (the level is held).
REQ-024 Latency from request to sd_rd/sd_wr SHALL be 2 cycles from IDLE.
REQ-025 sd_lba SHALL hold stable from grant until return to IDLE.

Reset
REQ-026 When rst_n=0 at a clock edge, the state SHALL be IDLE, sd_rd=sd_wr=0, sd_lba=0, grant=0, last=1 (port 0 first), err=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer; io_ackN and sd_buff_wrN SHALL be 0 from the next cycle.

Configuration
REQ-028 With macro SCSI_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL run in REQ and clear on leaving REQ.
REQ-029 With SCSI_ARB_TIMEOUT_EN defined, at count==TIMEOUT-1 the block SHALL drop sd_rd/sd_wr, drive io_ackN high for one cycle, set err, and return to IDLE.
REQ-030 Without SCSI_ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied 0, and REQ SHALL wait indefinitely.

Verification
REQ-031 Port0 io_rd0=1, io_lba0=0x10 -> sd_rd=1 and sd_lba=0x10 two cycles later; 3-cycle sd_ack pulse -> io_ack0 mirrors it, io_ack1=0, sd_rd low the cycle after sd_ack rises.
REQ-032 Both ports io_rd after reset -> port0 served first, then port1; repeat both -> port0 then port1 again (alternating).
REQ-033 Grant=1, sd_buff_wr=1, addr=0x1FF -> sd_buff_wr1=1, sd_buff_wr0=0, sd_buff_addr_o=0x1FF; sd_buff_din equals sd_buff_din1.
REQ-034 rst_n=0 while in ACK with sd_ack=1 -> next cycle busy=0, io_ack0=io_ack1=0, sd_rd=0.
REQ-035 SCSI_ARB_TIMEOUT_EN, TIMEOUT=16, io_wr1 with no sd_ack -> sd_wr low after 16 REQ cycles, io_ack1 one-cycle pulse, err=1 until reset.

Source files
------------

// File: rtl/scsi_io_arbiter_if.sv
// IO-controller side of the SCSI IO arbiter: block request handshake plus sector-buffer bus.
// master = arbiter, slave = IO controller.
interface scsi_io_arbiter_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/scsi_io_arbiter.sv
// Round-robin arbiter sharing one IO controller between two SCSI targets.
// Optional macro SCSI_ARB_TIMEOUT_EN adds a sd_ack timeout that sets the sticky err flag.
//
// Handshake: a target holds io_rdN/io_wrN (and io_lbaN) until it sees io_ackN. The arbiter raises
// sd_rd/sd_wr while in REQ; the controller answers with a sd_ack pulse, which is mirrored to the
// granted target only; the arbiter returns to IDLE when sd_ack falls.
module scsi_io_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_lba0,
  input  logic [31:0] io_lba1,
  input  logic        io_rd0,
  input  logic        io_wr0,
  input  logic        io_rd1,
  input  logic        io_wr1,
  output logic        io_ack0,
  output logic        io_ack1,
  input  logic [7:0]  sd_buff_din0,
  input  logic [7:0]  sd_buff_din1,
  output logic        sd_buff_wr0,
  output logic        sd_buff_wr1,
  output logic [8:0]  sd_buff_addr_o,
  output logic [7:0]  sd_buff_dout_o,
  scsi_io_arbiter_if.master sd,
  output logic        grant,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_dir_q, rd_dir_d;
  logic        sd_rd_q, sd_wr_q;
  logic [1:0]  rd_req_q, wr_req_q;
  logic [1:0]  pend;
  logic        sel;
  logic        to_ack;

  // Requests are sampled only while idle, so a level still held from the last transfer is never re-granted.
  assign pend = rd_req_q | wr_req_q;

`ifdef SCSI_ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        timeout_hit;
  logic        to_ack_q;
  logic        err_q;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    lba_d    = lba_q;
    rd_dir_d = rd_dir_q;
    sel      = 1'b0;
`ifdef SCSI_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
    cnt_d       = 24'd0;
`endif
    case (state_q)
      IDLE: begin
        if (|pend) begin
          // Both pending: prefer the port not served last.
          sel      = (pend == 2'b11) ? ~last_q : pend[1];
          grant_d  = sel;
          lba_d    = sel ? io_lba1 : io_lba0;
          rd_dir_d = rd_req_q[sel];
          state_d  = REQ;
        end
      end
      REQ: begin
        if (sd.sd_ack) begin
          state_d = ACK;
`ifdef SCSI_ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          state_d     = IDLE;
          last_d      = grant_q;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
`endif
        end
      end
      ACK: begin
        if (!sd.sd_ack) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      lba_q    <= 32'd0;
      rd_dir_q <= 1'b0;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
      rd_req_q <= 2'b00;
      wr_req_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      lba_q    <= lba_d;
      rd_dir_q <= rd_dir_d;
      sd_rd_q  <= (state_d == REQ) &  rd_dir_d;
      sd_wr_q  <= (state_d == REQ) & ~rd_dir_d;
      rd_req_q <= (state_q == IDLE) ? {io_rd1, io_rd0} : 2'b00;
      wr_req_q <= (state_q == IDLE) ? {io_wr1, io_wr0} : 2'b00;
    end
  end

`ifdef SCSI_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 24'd0;
      to_ack_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_ack_q <= timeout_hit;
      err_q    <= err_q | timeout_hit;
    end
  end
  assign to_ack = to_ack_q;
  assign err    = err_q;
`else
  assign to_ack = 1'b0;
  // No timeout logic in this build; TIMEOUT has no effect.
  assign err    = 1'b0 & (TIMEOUT != 24'd0);
`endif

  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign state_o = state_q;

  assign sd.sd_lba      = lba_q;
  assign sd.sd_rd       = sd_rd_q;
  assign sd.sd_wr       = sd_wr_q;
  assign sd.sd_buff_din = busy ? (grant_q ? sd_buff_din1 : sd_buff_din0) : 8'd0;

  assign io_ack0 = ((sd.sd_ack & busy) | to_ack) & ~grant_q;
  assign io_ack1 = ((sd.sd_ack & busy) | to_ack) &  grant_q;

  assign sd_buff_wr0    = sd.sd_buff_wr & busy & ~grant_q;
  assign sd_buff_wr1    = sd.sd_buff_wr & busy &  grant_q;
  assign sd_buff_addr_o = sd.sd_buff_addr;
  assign sd_buff_dout_o = sd.sd_buff_dout;
endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Self-checking bench for scsi_io_arbiter: directed reset/latency/alternation/reset-in-ACK steps
// followed by randomized transactions against a transaction-level round-robin model.
module tb_scsi_io_arbiter;
  localparam logic [23:0] TO = 24'd16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] io_lba0 = '0, io_lba1 = '0;
  logic        io_rd0 = 0, io_wr0 = 0, io_rd1 = 0, io_wr1 = 0;
  logic        io_ack0, io_ack1;
  logic [7:0]  sd_buff_din0 = '0, sd_buff_din1 = '0;
  logic        sd_buff_wr0, sd_buff_wr1;
  logic [8:0]  sd_buff_addr_o;
  logic [7:0]  sd_buff_dout_o;
  logic        grant, busy, err;
  logic [1:0]  dbg_state;

  scsi_io_arbiter_if sd_if();

  scsi_io_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_lba0(io_lba0), .io_lba1(io_lba1),
    .io_rd0(io_rd0), .io_wr0(io_wr0), .io_rd1(io_rd1), .io_wr1(io_wr1),
    .io_ack0(io_ack0), .io_ack1(io_ack1),
    .sd_buff_din0(sd_buff_din0), .sd_buff_din1(sd_buff_din1),
    .sd_buff_wr0(sd_buff_wr0), .sd_buff_wr1(sd_buff_wr1),
    .sd_buff_addr_o(sd_buff_addr_o), .sd_buff_dout_o(sd_buff_dout_o),
    .sd(sd_if.master),
    .grant(grant), .busy(busy), .err(err), .state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // model state: held target requests and the last port served
  logic        req_rd[2];
  logic        req_wr[2];
  logic [31:0] req_lba[2];
  logic        exp_last;
  int          last_lat;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reqs();
    io_rd0 = req_rd[0]; io_wr0 = req_wr[0]; io_lba0 = req_lba[0];
    io_rd1 = req_rd[1]; io_wr1 = req_wr[1]; io_lba1 = req_lba[1];
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < 2; p++) begin
      req_rd[p] = 1'b0; req_wr[p] = 1'b0; req_lba[p] = 32'd0;
    end
    apply_reqs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sd_if.sd_ack = 1'b0;
    sd_if.sd_buff_wr = 1'b0;
    clear_reqs();
    tick(); tick();
    rst_n = 1'b1;
    exp_last = 1'b1;
  endtask

  // One full transfer: model picks the port, bench plays the IO controller.
  task automatic run_txn();
    int          exp_port;
    logic        exp_rd;
    logic [31:0] exp_lba;
    int          n;
    bit          seen;
    int          k;
    logic [8:0]  a;
    logic [7:0]  d, d0, d1;
    logic        w;
    if ((req_rd[0] | req_wr[0]) && (req_rd[1] | req_wr[1])) exp_port = exp_last ? 0 : 1;
    else exp_port = (req_rd[1] | req_wr[1]) ? 1 : 0;
    exp_rd  = req_rd[exp_port];
    exp_lba = req_lba[exp_port];
    exp_q.push_back(exp_lba);

    seen = 0; n = 0;
    while (!seen && n < 8) begin
      tick(); n++;
      if (sd_if.sd_rd | sd_if.sd_wr) seen = 1;
    end
    last_lat = n;
    chk("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("grant", 32'(grant), 32'(exp_port));
    chk("sd_lba", sd_if.sd_lba, exp_q.pop_front());
    chk("sd_rd_dir", {sd_if.sd_rd, sd_if.sd_wr}, {exp_rd, ~exp_rd});
    chk("busy_req", 32'(busy), 32'd1);
    chk("no_ack_in_req", {io_ack0, io_ack1}, 32'd0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("lba_hold", sd_if.sd_lba, exp_lba);
      chk("dir_hold", {sd_if.sd_rd, sd_if.sd_wr}, {exp_rd, ~exp_rd});
    end

    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      sd_if.sd_ack = 1'b1;
      a  = (i == 0) ? 9'h1FF : 9'($urandom);
      w  = (i == 0) ? 1'b1 : 1'($urandom);
      d  = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
      sd_if.sd_buff_addr = a; sd_if.sd_buff_dout = d; sd_if.sd_buff_wr = w;
      sd_buff_din0 = d0; sd_buff_din1 = d1;
      #1;
      chk("io_ack0", 32'(io_ack0), 32'(exp_port == 0));
      chk("io_ack1", 32'(io_ack1), 32'(exp_port == 1));
      chk("buff_wr0", 32'(sd_buff_wr0), 32'(w && exp_port == 0));
      chk("buff_wr1", 32'(sd_buff_wr1), 32'(w && exp_port == 1));
      chk("buff_addr", 32'(sd_buff_addr_o), 32'(a));
      chk("buff_dout", 32'(sd_buff_dout_o), 32'(d));
      chk("buff_din", 32'(sd_if.sd_buff_din), 32'((exp_port == 1) ? d1 : d0));
      chk("lba_in_ack", sd_if.sd_lba, exp_lba);
      tick();
      chk("rd_low_after_ack", {sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
      if (i == 0) begin
        req_rd[exp_port] = 1'b0; req_wr[exp_port] = 1'b0;
        apply_reqs();
      end
    end
    sd_if.sd_ack = 1'b0;
    #1;
    chk("ack_released", {io_ack0, io_ack1}, 32'd0);
    tick();
    chk("idle_after", 32'(busy), 32'd0);
    chk("idle_buff_wr", {sd_buff_wr0, sd_buff_wr1}, 32'd0);
    chk("idle_buff_din", 32'(sd_if.sd_buff_din), 32'd0);
    sd_if.sd_buff_wr = 1'b0;
    exp_last = exp_port[0];
  endtask

  initial begin
    int   n;
    int   cnt;
    sd_if.sd_ack = 1'b0; sd_if.sd_buff_wr = 1'b0;
    sd_if.sd_buff_addr = '0; sd_if.sd_buff_dout = '0;
    do_reset();

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdwr", {sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
    chk("rst_lba", sd_if.sd_lba, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_acks", {io_ack0, io_ack1}, 32'd0);

    // single read on port 0, latency from IDLE
    req_rd[0] = 1'b1; req_lba[0] = 32'h10; apply_reqs();
    run_txn();
    chk("latency", 32'(last_lat), 32'd2);

    // both ports requesting: alternation twice
    req_rd[0] = 1'b1; req_lba[0] = 32'hA0; req_rd[1] = 1'b1; req_lba[1] = 32'hB1; apply_reqs();
    run_txn(); run_txn();
    req_rd[0] = 1'b1; req_lba[0] = 32'hA2; req_rd[1] = 1'b1; req_wr[1] = 1'b1; req_lba[1] = 32'hB3;
    apply_reqs();
    run_txn(); run_txn();

    // reset while in ACK with sd_ack high
    do_reset();
    req_rd[0] = 1'b1; req_lba[0] = 32'h55; apply_reqs();
    n = 0;
    while (!sd_if.sd_rd && n < 8) begin tick(); n++; end
    chk("rst_ack_seen", 32'(sd_if.sd_rd), 32'd1);
    sd_if.sd_ack = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_acks", {io_ack0, io_ack1}, 32'd0);
    chk("midrst_rd", 32'(sd_if.sd_rd), 32'd0);
    do_reset();

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req_rd[p] | req_wr[p]) && $urandom_range(0, 2) != 0) begin
          req_lba[p] = $urandom;
          case ($urandom_range(0, 3))
            0: req_rd[p] = 1'b1;
            1: req_wr[p] = 1'b1;
            2: begin req_rd[p] = 1'b1; req_wr[p] = 1'b1; end
            default: req_rd[p] = 1'b1;
          endcase
        end
      end
      if (!(req_rd[0] | req_wr[0] | req_rd[1] | req_wr[1])) begin
        req_wr[t % 2] = 1'b1; req_lba[t % 2] = $urandom;
      end
      apply_reqs();
      run_txn();
    end

`ifdef SCSI_ARB_TIMEOUT_EN
    do_reset();
    req_wr[1] = 1'b1; req_lba[1] = 32'hDEAD; apply_reqs();
    n = 0;
    while (!sd_if.sd_wr && n < 8) begin tick(); n++; end
    chk("to_wr_seen", 32'(sd_if.sd_wr), 32'd1);
    cnt = 0;
    while (sd_if.sd_wr && cnt < 40) begin cnt++; tick(); end
    chk("to_len", 32'(cnt), 32'(TO));
    chk("to_ack1", 32'(io_ack1), 32'd1);
    chk("to_ack0", 32'(io_ack0), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    req_wr[1] = 1'b0; apply_reqs();
    tick();
    chk("to_ack1_pulse", 32'(io_ack1), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("to_err_cleared", 32'(err), 32'd0);
`else
    cnt = 0;
    chk("err_tied", 32'(err), 32'(cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
